multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore FSM controller that sequences a multi-cycle MIPS-subset datapath over IF/ID/EXE/MEM/WB steps.
- Replaces single-cycle main control plus direct opcode decode for the multi-cycle CPU variant. The existing ALU control still consumes `ALUop` and `funct`.
- Sits between the instruction register (`OP` field), the ALU zero flag, the unified instruction/data memory ready line, and all datapath mux/write enables.
- Supported opcodes:
  - 000000 R-type
  - 001101 ori
  - 100011 lw
  - 101011 sw
  - 000100 beq
  - 000010 j

Parameters:
- OP_W, 6, opcode width
- ALUOP_W, 3, ALUop width fed to ALU control

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  synchronous active-high reset, sampled on rising edge of clk
- OP  in  6  opcode from instruction register (valid from ID onward)
- zero  in  1  ALU zero flag
- memReady  in  1  memory completes current access this cycle
- pcWrite  out  1  PC load enable (already combines unconditional write and branch-taken)
- IorD  out  1  0 = memory address from PC, 1 = from ALUOut
- memRead  out  1  memory read request
- memWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- regDst  out  1  1 = rd, 0 = rt
- memToReg  out  1  1 = MDR, 0 = ALUOut
- regWrite  out  1  register file write
- ALUsrcA  out  1  0 = PC, 1 = rs
- ALUsrcB  out  2  00 = rt, 01 = constant 4, 10 = ext(imm), 11 = ext(imm)<<2
- extop  out  1  1 = sign-extend, 0 = zero-extend
- PCsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUop  out  3  000 add, 001 sub, 010 or, 100 R-type (use funct)
- illegal  out  1  one-cycle pulse on unsupported opcode
- state  out  4  current state, for debug

Behaviour:
- State encoding (4 bits):
  - IF=0, ID=1, EXE_R=2, EXE_ORI=3, EXE_MA=4, EXE_BR=5, EXE_J=6
  - MEM_RD=7, MEM_WR=8, WB_R=9, WB_ORI=10, WB_LD=11
- Reset: while rst=1, every output is 0 (gated combinationally), including `state`. At the clock edge with rst=1 the state register becomes IF, and IF is the state after rst falls. Reset overrides any state, including mid-memory wait.
- Outputs are a pure decode of the state (Moore). The only input-dependent outputs:
  - `pcWrite`/`IRWrite` in IF (gated by memReady)
  - `pcWrite` in EXE_BR (equals zero)
  - `illegal` in ID
- Every output not listed for a state is 0; ALUop defaults to 000 and extop to 1.
- Per-state outputs and transitions:
  - IF: memRead=1, IorD=0, ALUsrcA=0, ALUsrcB=01, ALUop=000, PCsrc=00. IRWrite=pcWrite=memReady. Stay in IF while memReady=0; go to ID when memReady=1.
  - ID: ALUsrcA=0, ALUsrcB=11, extop=1, ALUop=000 (branch target into ALUOut). Next state by OP: 000000→EXE_R, 001101→EXE_ORI, 100011/101011→EXE_MA, 000100→EXE_BR, 000010→EXE_J. Any other OP: illegal=1 this cycle, next state IF.
  - EXE_R: ALUsrcA=1, ALUsrcB=00, ALUop=100. Next: WB_R.
  - EXE_ORI: ALUsrcA=1, ALUsrcB=10, extop=0, ALUop=010. Next: WB_ORI.
  - EXE_MA: ALUsrcA=1, ALUsrcB=10, extop=1, ALUop=000. Next: MEM_RD if OP=100011, else MEM_WR.
  - MEM_RD: memRead=1, IorD=1. Stay while memReady=0; go to WB_LD when memReady=1.
  - MEM_WR: memWrite=1, IorD=1. Stay while memReady=0; go to IF when memReady=1. memWrite is held high for the whole wait.
  - EXE_BR: ALUsrcA=1, ALUsrcB=00, ALUop=001, PCsrc=01, pcWrite=zero. Next: IF.
  - EXE_J: PCsrc=10, pcWrite=1. Next: IF.
  - WB_R: regDst=1, memToReg=0, regWrite=1. Next: IF.
  - WB_ORI: regDst=0, memToReg=0, regWrite=1. Next: IF.
  - WB_LD: regDst=0, memToReg=1, regWrite=1. Next: IF.
- Latency with memReady always 1, in cycles from entering IF: R-type 4, ori 4, lw 5, sw 4, beq 3, j 3. Each memory wait cycle adds 1.
- Exclusivity:
  - regWrite, memWrite and memRead are mutually exclusive in every state.
  - memWrite is never asserted outside MEM_WR.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- When defined, two extra outputs are present:
  - cycleCnt out 32: increments every cycle rst=0.
  - instrCnt out 32: increments on every transition into IF from a non-IF state, excluding the reset edge.
- Both counters clear to 0 under rst and wrap modulo 2^32.
- When undefined: the ports and counter logic are absent, and all other behaviour is identical.

Test Plan:
- Reset then OP=000000, memReady=1 → state sequence 0,1,2,9,0. regWrite=1 and regDst=1 only in cycle 4. ALUop=100 in cycle 3.
- OP=100011, memReady low for 2 cycles in MEM_RD → sequence 0,1,4,7,7,7,11,0 (7 cycles). IorD=1 only in the three MEM_RD cycles. memToReg=1 and regWrite=1 in WB_LD.
- OP=000100, zero=1 → pcWrite=1, PCsrc=01 in cycle 3. Repeat with zero=0 → pcWrite=0 in cycle 3. Both return to IF in cycle 4.
- OP=111111 → illegal=1 for exactly the ID cycle, next state IF, no regWrite or memWrite ever asserted.
- OP=101011, memReady=0, rst=1 on the 2nd MEM_WR cycle → memWrite=0 in that same cycle, state=IF after the edge. With MC_PERF_CNT_EN defined, both counters read 0.
- MC_PERF_CNT_EN defined: run ori, j, sw back-to-back with memReady=1 → instrCnt=3, cycleCnt=11 at return to IF.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore FSM sequencing a multi-cycle MIPS-subset datapath through IF/ID/EXE/MEM/WB.
// Define MC_PERF_CNT_EN to add the cycleCnt/instrCnt performance counter outputs.
module multicycle_control #(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    OP,
  input  logic               zero,
  input  logic               memReady,
  output logic               pcWrite,
  output logic               IorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               IRWrite,
  output logic               regDst,
  output logic               memToReg,
  output logic               regWrite,
  output logic               ALUsrcA,
  output logic [1:0]         ALUsrcB,
  output logic               extop,
  output logic [1:0]         PCsrc,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               illegal,
  output logic [3:0]         state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]        cycleCnt,
  output logic [31:0]        instrCnt
`endif
);

  typedef enum logic [3:0] {
    StIf     = 4'd0,
    StId     = 4'd1,
    StExeR   = 4'd2,
    StExeOri = 4'd3,
    StExeMa  = 4'd4,
    StExeBr  = 4'd5,
    StExeJ   = 4'd6,
    StMemRd  = 4'd7,
    StMemWr  = 4'd8,
    StWbR    = 4'd9,
    StWbOri  = 4'd10,
    StWbLd   = 4'd11
  } state_e;

  localparam logic [OP_W-1:0] OpRType = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OpOri   = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OpLw    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OpSw    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OpBeq   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OpJ     = OP_W'(6'b000010);

  localparam logic [ALUOP_W-1:0] AluAdd = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] AluSub = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] AluOr  = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] AluR   = ALUOP_W'(3'b100);

  state_e r_state;
  state_e w_state_nxt;
  logic   w_op_legal;

  assign w_op_legal = (OP == OpRType) || (OP == OpOri) || (OP == OpLw) ||
                      (OP == OpSw) || (OP == OpBeq) || (OP == OpJ);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIf;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; unused encodings fall back to IF
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIf:     w_state_nxt = memReady ? StId : StIf;
      StId: begin
        if (OP == OpRType) begin
          w_state_nxt = StExeR;
        end else if (OP == OpOri) begin
          w_state_nxt = StExeOri;
        end else if ((OP == OpLw) || (OP == OpSw)) begin
          w_state_nxt = StExeMa;
        end else if (OP == OpBeq) begin
          w_state_nxt = StExeBr;
        end else if (OP == OpJ) begin
          w_state_nxt = StExeJ;
        end else begin
          w_state_nxt = StIf;
        end
      end
      StExeR:   w_state_nxt = StWbR;
      StExeOri: w_state_nxt = StWbOri;
      StExeMa:  w_state_nxt = (OP == OpLw) ? StMemRd : StMemWr;
      StExeBr:  w_state_nxt = StIf;
      StExeJ:   w_state_nxt = StIf;
      StMemRd:  w_state_nxt = memReady ? StWbLd : StMemRd;
      StMemWr:  w_state_nxt = memReady ? StIf : StMemWr;
      StWbR:    w_state_nxt = StIf;
      StWbOri:  w_state_nxt = StIf;
      StWbLd:   w_state_nxt = StIf;
      default:  w_state_nxt = StIf;
    endcase
  end

  // Output decode; reset forces every output low, including extop and state
  always_comb begin
    pcWrite  = 1'b0;
    IorD     = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    IRWrite  = 1'b0;
    regDst   = 1'b0;
    memToReg = 1'b0;
    regWrite = 1'b0;
    ALUsrcA  = 1'b0;
    ALUsrcB  = 2'b00;
    extop    = 1'b0;
    PCsrc    = 2'b00;
    ALUop    = AluAdd;
    illegal  = 1'b0;
    state    = 4'd0;
    if (!rst) begin
      extop = 1'b1;
      state = r_state;
      unique case (r_state)
        StIf: begin
          memRead = 1'b1;
          ALUsrcB = 2'b01;
          IRWrite = memReady;
          pcWrite = memReady;
        end
        StId: begin
          ALUsrcB = 2'b11;
          illegal = ~w_op_legal;
        end
        StExeR: begin
          ALUsrcA = 1'b1;
          ALUop   = AluR;
        end
        StExeOri: begin
          ALUsrcA = 1'b1;
          ALUsrcB = 2'b10;
          extop   = 1'b0;
          ALUop   = AluOr;
        end
        StExeMa: begin
          ALUsrcA = 1'b1;
          ALUsrcB = 2'b10;
        end
        StExeBr: begin
          ALUsrcA = 1'b1;
          ALUop   = AluSub;
          PCsrc   = 2'b01;
          pcWrite = zero;
        end
        StExeJ: begin
          PCsrc   = 2'b10;
          pcWrite = 1'b1;
        end
        StMemRd: begin
          memRead = 1'b1;
          IorD    = 1'b1;
        end
        StMemWr: begin
          memWrite = 1'b1;
          IorD     = 1'b1;
        end
        StWbR: begin
          regDst   = 1'b1;
          regWrite = 1'b1;
        end
        StWbOri: begin
          regWrite = 1'b1;
        end
        StWbLd: begin
          memToReg = 1'b1;
          regWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;
  logic        w_instr_done;

  // An instruction retires on any entry into IF from another state
  assign w_instr_done = (r_state != StIf) && (w_state_nxt == StIf);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt <= 32'd0;
      r_instr_cnt <= 32'd0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_instr_done) begin
        r_instr_cnt <= r_instr_cnt + 32'd1;
      end
    end
  end

  assign cycleCnt = rst ? 32'd0 : r_cycle_cnt;
  assign instrCnt = rst ? 32'd0 : r_instr_cnt;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle vector table with scoreboard queue,
// plus a hand-written counter sequence when MC_PERF_CNT_EN is defined.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rdst;
    logic       m2r;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic       ext;
    logic [1:0] pcs;
    logic [2:0] aop;
    logic       ill;
  } out_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       zero;
    logic       mr;
    out_t       exp;
  } vec_t;

  localparam logic [5:0] OpR   = 6'b000000;
  localparam logic [5:0] OpOri = 6'b001101;
  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpSw  = 6'b101011;
  localparam logic [5:0] OpBeq = 6'b000100;
  localparam logic [5:0] OpJ   = 6'b000010;
  localparam logic [5:0] OpBad = 6'b111111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  OP = 6'd0;
  logic        zero = 1'b0;
  logic        memReady = 1'b1;
  logic        pcWrite, IorD, memRead, memWrite, IRWrite, regDst, memToReg, regWrite, ALUsrcA;
  logic [1:0]  ALUsrcB, PCsrc;
  logic        extop, illegal;
  logic [2:0]  ALUop;
  logic [3:0]  state;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycleCnt, instrCnt;
`endif

  int errors = 0;
  int checks = 0;

  multicycle_control dut (
    .clk      (clk),
    .rst      (rst),
    .OP       (OP),
    .zero     (zero),
    .memReady (memReady),
    .pcWrite  (pcWrite),
    .IorD     (IorD),
    .memRead  (memRead),
    .memWrite (memWrite),
    .IRWrite  (IRWrite),
    .regDst   (regDst),
    .memToReg (memToReg),
    .regWrite (regWrite),
    .ALUsrcA  (ALUsrcA),
    .ALUsrcB  (ALUsrcB),
    .extop    (extop),
    .PCsrc    (PCsrc),
    .ALUop    (ALUop),
    .illegal  (illegal),
    .state    (state)
`ifdef MC_PERF_CNT_EN
    ,
    .cycleCnt (cycleCnt),
    .instrCnt (instrCnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic out_t mk(input logic [3:0] st);
    out_t o;
    o     = '0;
    o.st  = st;
    o.ext = 1'b1;
    return o;
  endfunction

  function automatic out_t e_if(input logic mr);
    out_t o = mk(4'd0);
    o.mrd = 1'b1; o.asb = 2'b01; o.irw = mr; o.pcw = mr;
    return o;
  endfunction
  function automatic out_t e_id(input logic ill);
    out_t o = mk(4'd1);
    o.asb = 2'b11; o.ill = ill;
    return o;
  endfunction
  function automatic out_t e_exr();
    out_t o = mk(4'd2);
    o.asa = 1'b1; o.aop = 3'b100;
    return o;
  endfunction
  function automatic out_t e_exori();
    out_t o = mk(4'd3);
    o.asa = 1'b1; o.asb = 2'b10; o.ext = 1'b0; o.aop = 3'b010;
    return o;
  endfunction
  function automatic out_t e_exma();
    out_t o = mk(4'd4);
    o.asa = 1'b1; o.asb = 2'b10;
    return o;
  endfunction
  function automatic out_t e_exbr(input logic z);
    out_t o = mk(4'd5);
    o.asa = 1'b1; o.aop = 3'b001; o.pcs = 2'b01; o.pcw = z;
    return o;
  endfunction
  function automatic out_t e_exj();
    out_t o = mk(4'd6);
    o.pcs = 2'b10; o.pcw = 1'b1;
    return o;
  endfunction
  function automatic out_t e_memrd();
    out_t o = mk(4'd7);
    o.mrd = 1'b1; o.iord = 1'b1;
    return o;
  endfunction
  function automatic out_t e_memwr();
    out_t o = mk(4'd8);
    o.mwr = 1'b1; o.iord = 1'b1;
    return o;
  endfunction
  function automatic out_t e_wbr();
    out_t o = mk(4'd9);
    o.rdst = 1'b1; o.rw = 1'b1;
    return o;
  endfunction
  function automatic out_t e_wbori();
    out_t o = mk(4'd10);
    o.rw = 1'b1;
    return o;
  endfunction
  function automatic out_t e_wbld();
    out_t o = mk(4'd11);
    o.m2r = 1'b1; o.rw = 1'b1;
    return o;
  endfunction

  vec_t vecs[$];
  out_t sb[$];

  function automatic void add(input logic r, input logic [5:0] op, input logic z,
                              input logic mr, input out_t e);
    vec_t v;
    v.rst = r; v.op = op; v.zero = z; v.mr = mr; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic check_bit(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  initial begin
    out_t got;
    out_t exp;
    // Reset cycle, then R-type
    add(1, OpR, 0, 1, '0);
    add(0, OpR, 0, 1, e_if(1)); add(0, OpR, 0, 1, e_id(0));
    add(0, OpR, 0, 1, e_exr()); add(0, OpR, 0, 1, e_wbr());
    // IF stall, then lw with two MEM_RD wait cycles
    add(0, OpLw, 0, 0, e_if(0));
    add(0, OpLw, 0, 1, e_if(1)); add(0, OpLw, 0, 1, e_id(0)); add(0, OpLw, 0, 1, e_exma());
    add(0, OpLw, 0, 0, e_memrd()); add(0, OpLw, 0, 0, e_memrd()); add(0, OpLw, 0, 1, e_memrd());
    add(0, OpLw, 0, 1, e_wbld());
    // beq taken and not taken
    add(0, OpBeq, 1, 1, e_if(1)); add(0, OpBeq, 1, 1, e_id(0)); add(0, OpBeq, 1, 1, e_exbr(1));
    add(0, OpBeq, 0, 1, e_if(1)); add(0, OpBeq, 0, 1, e_id(0)); add(0, OpBeq, 0, 1, e_exbr(0));
    // Illegal opcode
    add(0, OpBad, 0, 1, e_if(1)); add(0, OpBad, 0, 1, e_id(1));
    // ori, j
    add(0, OpOri, 0, 1, e_if(1)); add(0, OpOri, 0, 1, e_id(0));
    add(0, OpOri, 0, 1, e_exori()); add(0, OpOri, 0, 1, e_wbori());
    add(0, OpJ, 0, 1, e_if(1)); add(0, OpJ, 0, 1, e_id(0)); add(0, OpJ, 0, 1, e_exj());
    // sw with one wait cycle
    add(0, OpSw, 0, 1, e_if(1)); add(0, OpSw, 0, 1, e_id(0)); add(0, OpSw, 0, 1, e_exma());
    add(0, OpSw, 0, 0, e_memwr()); add(0, OpSw, 0, 1, e_memwr());
    // sw interrupted by reset on the second MEM_WR cycle
    add(0, OpSw, 0, 1, e_if(1)); add(0, OpSw, 0, 1, e_id(0)); add(0, OpSw, 0, 1, e_exma());
    add(0, OpSw, 0, 0, e_memwr()); add(1, OpSw, 0, 0, '0);
    add(0, OpR, 0, 0, e_if(0));
    add(0, OpJ, 0, 1, e_if(1)); add(0, OpJ, 0, 1, e_id(0)); add(0, OpJ, 0, 1, e_exj());
    add(0, OpJ, 0, 1, e_if(1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst      = vecs[i].rst;
      OP       = vecs[i].op;
      zero     = vecs[i].zero;
      memReady = vecs[i].mr;
      sb.push_back(vecs[i].exp);
      @(negedge clk);
      got = {state, pcWrite, IorD, memRead, memWrite, IRWrite, regDst, memToReg, regWrite,
             ALUsrcA, ALUsrcB, extop, PCsrc, ALUop, illegal};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL vec%0d outputs: got %h, expected %h (state got %0d exp %0d)",
                 i, got, exp, got.st, exp.st);
      end
      check_bit($sformatf("vec%0d rw/mw/mr exclusive", i),
                32'($countones({regWrite, memWrite, memRead}) <= 1), 32'd1);
`ifdef MC_PERF_CNT_EN
      if (vecs[i].rst) begin
        check_bit($sformatf("vec%0d cycleCnt under reset", i), cycleCnt, 32'd0);
        check_bit($sformatf("vec%0d instrCnt under reset", i), instrCnt, 32'd0);
      end
`endif
    end
    check_bit("scoreboard drained", 32'(sb.size()), 32'd0);

`ifdef MC_PERF_CNT_EN
    begin
      logic [5:0] ops [11];
      ops = '{OpOri, OpOri, OpOri, OpOri, OpJ, OpJ, OpJ, OpSw, OpSw, OpSw, OpSw};
      @(posedge clk);
      #1;
      rst = 1'b1;
      memReady = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_bit("cycleCnt after reset", cycleCnt, 32'd0);
      for (int k = 0; k < 11; k++) begin
        OP = ops[k];
        @(posedge clk);
        #1;
      end
      check_bit("state back in IF", 32'(state), 32'd0);
      check_bit("cycleCnt ori+j+sw", cycleCnt, 32'd11);
      check_bit("instrCnt ori+j+sw", instrCnt, 32'd3);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
